// File: rtl/implication_responder.sv
// implication_responder
// Answers each accepted request pulse on a_in with exactly one b_out pulse,
// LATENCY cycles later. Responses that come due while the consumer stalls
// are parked in a saturating pending counter. They are released one per
// cycle once stall drops.

module implication_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          a_in,
  input  logic          stall,
  output logic          b_out,
  output logic [CW-1:0] pending,
  output logic          busy,
  output logic          overflow
);

  // The delay line has LATENCY-1 stages. It keeps a single dummy stage when
  // LATENCY is 1, so the declarations stay legal; that stage is held at zero.
  localparam int DLW = (LATENCY > 1) ? (LATENCY - 1) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  logic           req;
  logic           arr;
  logic           issue;
  logic           drop;
  logic [DLW-1:0] dl;
  logic [DLW-1:0] dl_next;
  logic [CW-1:0]  pending_next;
  logic           busy_next;

  // Accept requests and shift them down the delay line. The tail becomes the arrival.
  always_comb begin
    req     = a_in & en;
    dl_next = {DLW{1'b0}};
    arr     = 1'b0;
    if (LATENCY == 1) begin
      dl_next = {DLW{1'b0}};
      arr     = req;
    end else begin
      dl_next = DLW'({dl, req});
      arr     = dl[DLW-1];
    end
  end

  // Decide the issue, the drop and the next pending count for this cycle.
  always_comb begin
    issue        = !stall && ((pending != ZERO_C) || arr);
    drop         = (pending == DEPTH_C) && arr && !issue;
    pending_next = pending;
    if (drop) begin
      pending_next = pending;
    end else if (arr && !issue) begin
      pending_next = pending + ONE_C;
    end else if (!arr && issue) begin
      pending_next = pending - ONE_C;
    end else begin
      pending_next = pending;
    end
    // busy also covers the cycle in which the response itself is on b_out.
    busy_next = (dl_next != {DLW{1'b0}}) || (pending_next != ZERO_C) || issue;
  end

  // Register the delay line, the counter and all outputs. Reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dl       <= {DLW{1'b0}};
      pending  <= ZERO_C;
      b_out    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl       <= dl_next;
      pending  <= pending_next;
      b_out    <= issue;
      busy     <= busy_next;
      overflow <= overflow | drop;
    end
  end

endmodule

// File: tb/tb_implication_responder.sv
// Directed and randomised checks for implication_responder with LATENCY=2
// and DEPTH=4. Outputs are sampled 1ns after each rising edge. The value
// seen after edge k is the value the design presents at edge k+1.
module tb_implication_responder;

  localparam int LAT = 2;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP + 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic          a_in;
  logic          stall;
  logic          b_out;
  logic [CW-1:0] pending;
  logic          busy;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  implication_responder #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .a_in     (a_in),
    .stall    (stall),
    .b_out    (b_out),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int first_at;
    int mp;
    int drops;
    int nreq;
    int nresp;
    logic prev_req;
    logic arr_m;
    logic issue_m;

    rst = 1'b0; en = 1'b1; a_in = 1'b0; stall = 1'b0;
    tick(); tick();
    chk("rst_b_out", 32'(b_out), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    tick();

    // Single request: a response one edge after the request edge, then quiet.
    a_in = 1'b1; tick(); a_in = 1'b0;
    chk("single_b0", 32'(b_out), 32'd0);
    chk("single_busy0", 32'(busy), 32'd1);
    tick();
    chk("single_b1", 32'(b_out), 32'd1);
    chk("single_busy1", 32'(busy), 32'd1);
    chk("single_pend", 32'(pending), 32'd0);
    tick();
    chk("single_b2", 32'(b_out), 32'd0);
    chk("single_busy2", 32'(busy), 32'd0);
    tick(); tick();

    // Back-to-back: five requests give exactly five consecutive responses.
    pulses = 0; first_at = -1;
    for (int i = 0; i < 10; i++) begin
      a_in = (i < 5);
      tick();
      if (b_out) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
      if (i >= 1 && i <= 5) chk("b2b_b_on", 32'(b_out), 32'd1);
    end
    a_in = 1'b0;
    chk("b2b_count", 32'(pulses), 32'd5);
    chk("b2b_first", 32'(first_at), 32'd1);
    chk("b2b_pend", 32'(pending), 32'd0);
    chk("b2b_ovf", 32'(overflow), 32'd0);

    // Stall: three requests accumulate and are drained after release.
    stall = 1'b1;
    for (int i = 0; i < 11; i++) begin
      a_in = (i < 3);
      tick();
      chk("stall_b_low", 32'(b_out), 32'd0);
    end
    a_in = 1'b0;
    chk("stall_pend3", 32'(pending), 32'd3);
    chk("stall_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    tick(); chk("drain_b1", 32'(b_out), 32'd1); chk("drain_p2", 32'(pending), 32'd2);
    tick(); chk("drain_b2", 32'(b_out), 32'd1); chk("drain_p1", 32'(pending), 32'd1);
    tick(); chk("drain_b3", 32'(b_out), 32'd1); chk("drain_p0", 32'(pending), 32'd0);
    tick(); chk("drain_b4", 32'(b_out), 32'd0); chk("drain_busy", 32'(busy), 32'd0);

    // Enable gating: three blocked pulses, then one accepted pulse.
    pulses = 0; first_at = -1;
    for (int i = 0; i < 10; i++) begin
      en   = (i >= 5);
      a_in = (i < 3) || (i == 5);
      tick();
      if (b_out) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
    en = 1'b1; a_in = 1'b0;
    chk("en_count", 32'(pulses), 32'd1);
    chk("en_at", 32'(first_at), 32'd6);

    // Overflow: six stalled requests; four kept, two dropped, flag sticky.
    stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_in = (i < 6);
      tick();
    end
    a_in = 1'b0;
    chk("ovf_pend", 32'(pending), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    stall = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b_out) pulses++;
    end
    chk("ovf_pulses", 32'(pulses), 32'd4);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_pend0", 32'(pending), 32'd0);

    // Reset mid-operation: pending=2 and one request in flight, then reset.
    stall = 1'b1;
    a_in = 1'b1; tick(); tick(); tick();
    a_in = 1'b0;
    chk("mid_pend2", 32'(pending), 32'd2);
    rst = 1'b0; tick(); rst = 1'b1; stall = 1'b0;
    chk("mid_b", 32'(b_out), 32'd0);
    chk("mid_pend", 32'(pending), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b_out) pulses++;
    end
    chk("mid_no_b", 32'(pulses), 32'd0);

    // Random run against a cycle model of the pending queue.
    mp = 0; drops = 0; nreq = 0; nresp = 0; prev_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a_in  = ($urandom_range(0, 2) == 0);
      stall = ($urandom_range(0, 3) == 0);
      en    = 1'b1;
      arr_m   = prev_req;
      issue_m = !stall && (mp != 0 || arr_m);
      if (mp == DEP && arr_m && !issue_m) drops++;
      else mp = mp + int'(arr_m) - int'(issue_m);
      tick();
      chk("rnd_b", 32'(b_out), 32'(issue_m));
      chk("rnd_pend", 32'(pending), 32'(mp));
      if (prev_req && !stall) chk("rnd_impl", 32'(b_out), 32'd1);
      if (b_out) nresp++;
      if (a_in && en) nreq++;
      prev_req = a_in & en;
    end
    a_in = 1'b0; stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_out) nresp++;
    end
    chk("rnd_balance", 32'(nresp), 32'(nreq - drops));
    chk("rnd_idle", 32'(busy), 32'd0);
    chk("rnd_ovf", 32'(overflow), 32'(drops != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
